// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: functional-unit result handshake plus CDB broadcast bundle.
// Latency: none, this is wiring only.
// Backpressure: req_ready is the per-unit grant; the CDB side has no backpressure.
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic                      flush;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
    logic [SRC_W-1:0]          cdb_src;

    // Functional units / pipeline control side
    modport master (
        output flush, req_valid, req_tag, req_data,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    // Arbiter side
    modport slave (
        input  flush, req_valid, req_tag, req_data,
        output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the CDB between FUs, round-robin (fixed priority, unit 0 first, with CDB_ARB_FIXED_PRIO_EN).
// Latency: 1 cycle from grant (req_valid & req_ready) to broadcast on the registered CDB.
// Backpressure: req_ready is a combinational one-hot grant; losers, flush and reset cycles leave results held at the FU.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32
) (
    input  logic         clk,
    input  logic         rst,
    cdb_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic              gnt_found;
    logic              gnt_fire;
    logic [SRC_W-1:0]  gnt_idx;
    logic [TAG_W-1:0]  sel_tag;
    logic [DATA_W-1:0] sel_data;

    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q,  cdb_data_d;
    logic [SRC_W-1:0]  cdb_src_q,   cdb_src_d;

`ifndef CDB_ARB_FIXED_PRIO_EN
    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
`endif

    // Grant search: scan backwards so the last hit is the first valid unit from the priority origin
    always_comb begin
        logic [SRC_W-1:0] cand;
        cand      = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef CDB_ARB_FIXED_PRIO_EN
            cand = SRC_W'(k);
`else
            cand = SRC_W'((int'(rr_ptr_q) + k) % NUM_REQ);
`endif
            if (bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Grant qualification and one-hot ready; flush and reset block every transfer
    always_comb begin
        gnt_fire      = gnt_found & ~bus.flush & ~rst;
        bus.req_ready = '0;
        if (gnt_fire) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
        sel_tag  = bus.req_tag[int'(gnt_idx)*TAG_W +: TAG_W];
        sel_data = bus.req_data[int'(gnt_idx)*DATA_W +: DATA_W];
    end

    // Next CDB contents: the winner, or an idle bus with tag/data zeroed and source held
    always_comb begin
        cdb_valid_d = gnt_fire;
        cdb_tag_d   = '0;
        cdb_data_d  = '0;
        cdb_src_d   = cdb_src_q;
        if (gnt_fire) begin
            cdb_tag_d  = sel_tag;
            cdb_data_d = sel_data;
            cdb_src_d  = gnt_idx;
        end
`ifndef CDB_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
        if (gnt_fire) begin
            rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + SRC_W'(1);
        end
`endif
    end

    // CDB output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
`ifndef CDB_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
`ifndef CDB_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed test-plan sequences then random FU traffic with flush and reset.
// Latency: expected broadcast is queued at grant time and checked one posedge later.
// Backpressure: requesters hold their result until the reference model says it was granted.
module tb_cdb_arbiter;
    localparam int N = 4;
    localparam int T = 3;
    localparam int D = 32;

    typedef struct {
        logic         vld;
        logic [T-1:0] tag;
        logic [D-1:0] data;
        logic [1:0]   src;
    } exp_t;

    logic clk;
    logic rst;
    cdb_arbiter_if #(.NUM_REQ(N), .TAG_W(T), .DATA_W(D)) bus ();

    cdb_arbiter #(.NUM_REQ(N), .TAG_W(T), .DATA_W(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // requester state and scoreboard
    logic         r_vld  [N];
    logic [T-1:0] r_tag  [N];
    logic [D-1:0] r_data [N];
    logic         flush_s;
    exp_t         sbq[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc   = 0;
    int           m_ptr = 0;
    int           m_src = 0;
    int           last_win = -1;

    // One clock of stimulus: drive, predict, check ready, queue the expected CDB
    task automatic step();
        logic [N-1:0] exp_rdy;
        exp_t e;
        int win;
        int idx;
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]          = r_vld[i];
            bus.req_tag[i*T +: T]     = r_tag[i];
            bus.req_data[i*D +: D]    = r_data[i];
        end
        bus.flush = flush_s;
        #1;
        win = -1;
        if (!rst && !flush_s) begin
            for (int k = 0; k < N; k++) begin
`ifdef CDB_ARB_FIXED_PRIO_EN
                idx = k;
`else
                idx = (m_ptr + k) % N;
`endif
                if (win < 0 && r_vld[idx]) win = idx;
            end
        end
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        n_cmp++;
        if (bus.req_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_rdy);
        end
        if (rst) begin
            e = '{vld: 1'b0, tag: '0, data: '0, src: 2'd0};
            m_ptr = 0;
            m_src = 0;
        end else if (win >= 0) begin
            e = '{vld: 1'b1, tag: r_tag[win], data: r_data[win], src: 2'(win)};
            m_src = win;
            m_ptr = (win + 1) % N;
        end else begin
            e = '{vld: 1'b0, tag: '0, data: '0, src: 2'(m_src)};
        end
        sbq.push_back(e);
        last_win = win;
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            r_vld[i]  = 1'b0;
            r_tag[i]  = '0;
            r_data[i] = '0;
        end
    endtask

    task automatic all_four();
        for (int i = 0; i < N; i++) begin
            r_vld[i]  = 1'b1;
            r_tag[i]  = T'(4 + i);
            r_data[i] = D'(7 + 2 * i);
        end
    endtask

    // Monitor: compare the whole CDB against the oldest expectation after each posedge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_cmp++;
                if (bus.cdb_valid !== e.vld || bus.cdb_tag !== e.tag ||
                    bus.cdb_data !== e.data || bus.cdb_src !== e.src) begin
                    n_err++;
                    $display("FAIL cdb t=%0t got v=%b tag=%0d data=%h src=%0d exp v=%b tag=%0d data=%h src=%0d",
                             $time, bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.cdb_src,
                             e.vld, e.tag, e.data, e.src);
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        flush_s = 1'b0;
        clear_reqs();
        // reset, then idle
        step();
        step();
        rst = 1'b0;
        repeat (5) step();
        // single request from unit 1
        r_vld[1] = 1'b1; r_tag[1] = 3'd1; r_data[1] = 32'h2;
        step();
        clear_reqs();
        step();
        // all four continuously from rr_ptr 0
        rst = 1'b1; step(); rst = 1'b0;
        all_four();
        repeat (5) step();
        // reset mid-stream, first grant afterwards goes to unit 0
        rst = 1'b1; step(); rst = 1'b0;
        repeat (3) step();
        // wrap: move pointer to 3, then units 3 and 0 compete
        clear_reqs();
        r_vld[2] = 1'b1; r_tag[2] = 3'd2; r_data[2] = 32'hA2;
        step();
        clear_reqs();
        r_vld[3] = 1'b1; r_tag[3] = 3'd3; r_data[3] = 32'hB3;
        r_vld[0] = 1'b1; r_tag[0] = 3'd0; r_data[0] = 32'hB0;
        repeat (4) step();
        // flush for two cycles, then grant unit 2
        clear_reqs();
        step();
        r_vld[2] = 1'b1; r_tag[2] = 3'd6; r_data[2] = 32'hC2;
        flush_s = 1'b1;
        repeat (2) step();
        flush_s = 1'b0;
        step();
        clear_reqs();
        step();
        // random traffic obeying the hold-until-granted rule
        for (int n = 0; n < 1500; n++) begin
            rst     = ($urandom_range(0, 49) == 0);
            flush_s = ($urandom_range(0, 9) == 0);
            step();
            for (int i = 0; i < N; i++) begin
                if (i == last_win || !r_vld[i]) begin
                    if ((i == last_win) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0)) begin
                        r_vld[i]  = 1'b1;
                        r_tag[i]  = T'($urandom);
                        r_data[i] = $urandom;
                    end else begin
                        r_vld[i]  = 1'b0;
                    end
                end
            end
        end
        rst = 1'b0; flush_s = 1'b0;
        clear_reqs();
        step();
        @(posedge clk);
        #2;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain left=%0d exp=0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
